// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS pipeline encodings and address map defaults
package mips_pkg;

  typedef enum logic [3:0] {
    BR_NONE = 4'd0,
    BR_BEQ  = 4'd1,
    BR_BNE  = 4'd2,
    BR_BGEZ = 4'd3,
    BR_BLTZ = 4'd4,
    BR_BLEZ = 4'd5,
    BR_BGTZ = 4'd6,
    BR_J    = 4'd7,
    BR_JAL  = 4'd8,
    BR_JR   = 4'd9,
    BR_JALR = 4'd10
  } br_op_e;

  typedef enum logic [1:0] {
    TSEL_BR = 2'd0,
    TSEL_J  = 2'd1,
    TSEL_JR = 2'd2
  } tsel_e;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] DEF_EXC_VEC  = 32'h0000_4180;
  localparam logic [31:0] DEF_IM_LO    = 32'h0000_3000;
  localparam logic [31:0] DEF_IM_HI    = 32'h0000_6FFC;

endpackage

// File: rtl/br_cond.sv
// rtl/br_cond.sv - branch condition decode and target-select for the ID stage
module br_cond
  import mips_pkg::*;
(
  input  logic [3:0] br_op,
  input  logic       cmp_eq,
  input  logic       cmp_gez,
  input  logic       cmp_ez,
  output logic       taken,
  output tsel_e      tsel
);

  always_comb begin
    taken = 1'b0;
    tsel  = TSEL_BR;
    case (br_op)
      BR_BEQ:  taken = cmp_eq;
      BR_BNE:  taken = !cmp_eq;
      BR_BGEZ: taken = cmp_gez;
      BR_BLTZ: taken = !cmp_gez;
      BR_BLEZ: taken = !cmp_gez || cmp_ez;
      BR_BGTZ: taken = cmp_gez && !cmp_ez;
      BR_J, BR_JAL: begin
        taken = 1'b1;
        tsel  = TSEL_J;
      end
      BR_JR, BR_JALR: begin
        taken = 1'b1;
        tsel  = TSEL_JR;
      end
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/npc_ctrl.sv
// rtl/npc_ctrl.sv - IF-stage PC register with ID-stage branch resolution and exception/eret arbitration
module npc_ctrl
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] EXC_VEC  = DEF_EXC_VEC,
  parameter logic [31:0] IM_LO    = DEF_IM_LO,
  parameter logic [31:0] IM_HI    = DEF_IM_HI
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [3:0]  br_op,
  input  logic        cmp_eq,
  input  logic        cmp_gez,
  input  logic        cmp_ez,
  input  logic [31:0] pc_id,
  input  logic [15:0] imm16,
  input  logic [25:0] instr_index,
  input  logic [31:0] jr_target,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  output logic [31:0] pc_if,
  output logic [31:0] link_addr,
  output logic        taken,
  output logic        bd_if,
  output logic        fetch_adel
);

  logic [31:0] pc_q, pc_d;
  logic        bd_q, bd_d;
  logic        adel_q, adel_d;
  logic [31:0] pc_plus4_id;
  logic [31:0] target;
  tsel_e       tsel;

  br_cond u_br_cond (
    .br_op   (br_op),
    .cmp_eq  (cmp_eq),
    .cmp_gez (cmp_gez),
    .cmp_ez  (cmp_ez),
    .taken   (taken),
    .tsel    (tsel)
  );

  always_comb begin
    pc_plus4_id = pc_id + 32'd4;
    link_addr   = pc_id + 32'd8;
    case (tsel)
      TSEL_J:  target = {pc_plus4_id[31:28], instr_index, 2'b00};
      TSEL_JR: target = jr_target;
      default: target = pc_plus4_id + {{14{imm16[15]}}, imm16, 2'b00};
    endcase
  end

  // Priority: exception > eret > stall > redirect > sequential.
  always_comb begin
    pc_d = pc_q + 32'd4;
    bd_d = 1'b0;
    if (exc_req) begin
      pc_d = EXC_VEC;
    end else if (eret_req) begin
      pc_d = epc;
    end else if (stall) begin
      pc_d = pc_q;
      bd_d = bd_q;
    end else begin
      bd_d = (br_op != BR_NONE);
      if (taken) pc_d = target;
    end
    adel_d = (pc_d[1:0] != 2'b00) || (pc_d < IM_LO) || (pc_d > IM_HI);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q   <= RESET_PC;
      bd_q   <= 1'b0;
      adel_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      bd_q   <= bd_d;
      adel_q <= adel_d;
    end
  end

  assign pc_if      = pc_q;
  assign bd_if      = bd_q;
  assign fetch_adel = adel_q;

endmodule
